fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Pointer and flag controller for the team's synchronous FIFO. It sequences the write and read pointers, built from the shared enable counter, and drives address and enable strobes to an external dual-port RAM. It generates full, empty, almost-full and almost-empty flags, an occupancy level, a read-data-valid strobe and sticky overflow/underflow errors. It sits between the producer/consumer handshakes and the storage array.

## Interface
- `AW`, 4: address width; depth = 2^AW (16).
- `AF_THR`, 12: almost_full asserted when level >= AF_THR.
- `AE_THR`, 4: almost_empty asserted when level <= AE_THR.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_req`  in  1  producer write request.
- `rd_req`  in  1  consumer read request.
- `clr_err`  in  1  synchronous clear of sticky errors.
- `mem_we`  out  1  RAM write enable (= accepted write).
- `mem_re`  out  1  RAM read enable (= accepted read).
- `waddr`  out  AW  RAM write address.
- `raddr`  out  AW  RAM read address.
- `rd_valid`  out  1  RAM output data valid.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  status flags.
- `level`  out  AW+1  occupancy, 0..2^AW.
- `overflow`, `underflow`  out  1 each  sticky error flags.

## Operation
- Pointers `wptr` and `rptr` are AW+1 bits wide. The low AW bits drive `waddr` and `raddr`; the MSB is the wrap bit. Each pointer increments by 1 modulo 2^(AW+1) on accept.
- `level` = (wptr − rptr) mod 2^(AW+1).
- `empty` = (wptr == rptr). `full` = (MSBs differ) and (low AW bits equal).
- Accept rules:
  - wr_acc = wr_req & (~full | rd_req)
  - rd_acc = rd_req & ~empty
- At full, a simultaneous read and write are both accepted, and level stays at 2^AW.
- At empty, a simultaneous read and write accept the write only; the read is rejected.
- `mem_we` = wr_acc and `mem_re` = rd_acc. Both are combinational from the current requests and registered state.
- `overflow` sets on wr_req & ~wr_acc. `underflow` sets on rd_req & ~rd_acc.
- Both error flags hold until a clr_err cycle. If set and clear occur in the same cycle, set wins.
- Rejected requests never move pointers.
- Flags and level decode combinationally from the pointer registers. They are therefore glitch-free state plus a decode, with no dependence on current-cycle requests.

## Timing
- Reset values: wptr = rptr = 0, level = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = underflow = 0, rd_valid = 0.
- `mem_we` and `mem_re` are 0 during reset because empty = 1 and no write is accepted while rst is high.
- Pointer update, flags and level reflect an accepted operation in the cycle after the accepting edge.
- Read latency: the RAM registers the read. `rd_valid` is a register of rd_acc and is high exactly one cycle after mem_re.
- Reset mid-operation immediately empties the FIFO logically and drops any pending rd_valid. RAM contents are not cleared.
- Wrap-around: after 2^(AW+1) accepted operations, a pointer returns to 0. Full/empty stay correct across every wrap.

## Structure
- Shared package holds:
  - pointer-width function AW+1
  - depth constant 2^AW
  - flag-bundle typedef: full, empty, almost_full, almost_empty
- One sub-module, instantiated twice: the team's `counter` with K = AW+1 and `en` driven by wr_acc or rd_acc. Its asynchronous reset is tied to `rst`.
- Threshold comparators, accept logic, error registers and `rd_valid` live in the top level.
- The RAM is external.

## Test plan
- Reset, then idle: empty = 1, almost_empty = 1, level = 0, all other outputs 0, no mem_we or mem_re.
- 16 back-to-back writes: waddr 0..15, level 0→16. almost_full rises when level reaches 12 and full rises at 16. A 17th wr_req with rd_req low is rejected and overflow = 1 and stays high until clr_err.
- Full, then wr_req and rd_req together for 5 cycles: both accepted each cycle, level stays 16. rd_valid pulses one cycle after each mem_re.
- Empty, then wr_req and rd_req together: the write is accepted, the read is rejected, underflow = 1, and level = 1 next cycle.
- Stream 40 writes with interleaved reads keeping level between 2 and 8: pointers wrap past 31→0, with no false full or empty. almost_empty toggles across level 4.
- Assert rst with level = 9 and a read in flight: next cycle level = 0, empty = 1 and rd_valid = 0. Sticky errors are also cleared.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO pointer/flag controller: pointer width,
// default depth and the status flag bundle.
package fifo_ctrl_pkg;

  localparam int unsigned DEF_AW = 4;
  localparam int unsigned DEPTH  = 2 ** DEF_AW;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int unsigned ptr_w(input int unsigned aw);
    return aw + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } flags_t;

endpackage

// File: rtl/fifo_ctrl_counter.sv
// Shared enable counter: K-bit up counter, wraps modulo 2^K, async reset.
module counter #(
  parameter int K = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [K-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= q + K'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for the synchronous FIFO; drives the strobes
// and addresses of an external dual-port RAM with a registered read port.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int AW     = 4,
  parameter int AF_THR = 12,
  parameter int AE_THR = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic          clr_err,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] raddr,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          underflow
);

  localparam int PW = ptr_w(AW);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          wr_acc;
  logic          rd_acc;
  flags_t        flags;

  // Handshake: a request is accepted in the cycle it is presented if the
  // accept term is high; a rejected request is dropped (never queued) and
  // raises the matching sticky error. Nothing is accepted while rst is high.
  assign wr_acc = wr_req & ~rst & (~flags.full | rd_req);
  assign rd_acc = rd_req & ~rst & ~flags.empty;

  counter #(.K(PW)) u_wcnt (
    .clk (clk),
    .rst (rst),
    .en  (wr_acc),
    .q   (wptr)
  );

  counter #(.K(PW)) u_rcnt (
    .clk (clk),
    .rst (rst),
    .en  (rd_acc),
    .q   (rptr)
  );

  // Flags depend only on the pointer registers, never on this cycle's requests.
  assign level              = wptr - rptr;
  assign flags.empty        = (wptr == rptr);
  assign flags.full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign flags.almost_full  = (level >= PW'(AF_THR));
  assign flags.almost_empty = (level <= PW'(AE_THR));

  assign full         = flags.full;
  assign empty        = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;

  assign mem_we = wr_acc;
  assign mem_re = rd_acc;
  assign waddr  = wptr[AW-1:0];
  assign raddr  = rptr[AW-1:0];

  // Set has priority over clear so an error in the clearing cycle is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      overflow  <= (wr_req & ~wr_acc) | (overflow  & ~clr_err);
      underflow <= (rd_req & ~rd_acc) | (underflow & ~clr_err);
      rd_valid  <= rd_acc;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl (AW=4, AF_THR=12, AE_THR=4).
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req, rd_req, clr_err;
  logic       mem_we, mem_re, rd_valid;
  logic [3:0] waddr, raddr;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] level;
  logic       overflow, underflow;

  int errors = 0;
  int checks = 0;
  int lvl;
  logic [4:0] exp_w, exp_r;

  fifo_ctrl #(.AW(4), .AF_THR(12), .AE_THR(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .clr_err      (clr_err),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .waddr        (waddr),
    .raddr        (raddr),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change on the falling edge, checks follow #1 after
  task automatic set_req(input logic w, input logic r, input logic c);
    @(negedge clk);
    wr_req  = w;
    rd_req  = r;
    clr_err = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1; clr_err = 1'b0;
    #12;
    checks++;
    if ({mem_we, mem_re, level, empty} !== {2'b00, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_active: got we/re/level/empty=%b %b %0d %b want 0 0 0 1",
               mem_we, mem_re, level, empty);
    end
    @(negedge clk);
    rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    tick(); tick();
    checks++;
    if ({empty, almost_empty, full, almost_full, overflow, underflow, rd_valid, mem_we, mem_re}
        !== 9'b110000000) begin
      errors++;
      $display("FAIL reset_idle_flags: got %b want 110000000",
               {empty, almost_empty, full, almost_full, overflow, underflow, rd_valid, mem_we, mem_re});
    end
    checks++;
    if ({level, waddr, raddr} !== 13'd0) begin
      errors++;
      $display("FAIL reset_idle_ptrs: got level=%0d waddr=%0d raddr=%0d want 0 0 0", level, waddr, raddr);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b1, 1'b0, 1'b0);
      checks++;
      if ({mem_we, mem_re, waddr} !== {2'b10, 4'(i)}) begin
        errors++;
        $display("FAIL fill_strobe[%0d]: got we=%b re=%b waddr=%0d want 1 0 %0d", i, mem_we, mem_re, waddr, i);
      end
      tick();
      checks++;
      if ({level, almost_full, full, empty} !== {5'(i + 1), (i + 1 >= 12), (i + 1 == 16), 1'b0}) begin
        errors++;
        $display("FAIL fill_flags[%0d]: got level=%0d af=%b full=%b empty=%b want %0d %b %b 0",
                 i, level, almost_full, full, empty, i + 1, (i + 1 >= 12), (i + 1 == 16));
      end
    end
    set_req(1'b1, 1'b0, 1'b0);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL overflow_reject: got mem_we=%b want 0", mem_we);
    end
    tick();
    checks++;
    if ({overflow, level, waddr} !== {1'b1, 5'd16, 4'd0}) begin
      errors++;
      $display("FAIL overflow_set: got ovf=%b level=%0d waddr=%0d want 1 16 0", overflow, level, waddr);
    end
    set_req(1'b0, 1'b0, 1'b0);
    tick(); tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b want 1", overflow);
    end
    set_req(1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got %b want 0", overflow);
    end
    lvl = 16; exp_w = 5'd16; exp_r = 5'd0;
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 1'b1, 1'b0);
      checks++;
      if ({mem_we, mem_re, waddr, raddr} !== {2'b11, 4'(i), 4'(i)}) begin
        errors++;
        $display("FAIL full_rw_strobe[%0d]: got we=%b re=%b waddr=%0d raddr=%0d want 1 1 %0d %0d",
                 i, mem_we, mem_re, waddr, raddr, i, i);
      end
      tick();
      checks++;
      if ({level, full, rd_valid, overflow} !== {5'd16, 3'b110}) begin
        errors++;
        $display("FAIL full_rw_state[%0d]: got level=%0d full=%b rd_valid=%b ovf=%b want 16 1 1 0",
                 i, level, full, rd_valid, overflow);
      end
    end
    set_req(1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({rd_valid, level} !== {1'b0, 5'd16}) begin
      errors++;
      $display("FAIL full_rw_idle: got rd_valid=%b level=%0d want 0 16", rd_valid, level);
    end
    exp_w = 5'd21; exp_r = 5'd5;
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b0, 1'b1, 1'b0);
      checks++;
      if ({mem_re, raddr} !== {1'b1, 4'(5 + i)}) begin
        errors++;
        $display("FAIL drain_strobe[%0d]: got re=%b raddr=%0d want 1 %0d", i, mem_re, raddr, (5 + i) % 16);
      end
      tick();
      checks++;
      if ({level, empty, almost_empty} !== {5'(15 - i), (i == 15), (15 - i <= 4)}) begin
        errors++;
        $display("FAIL drain_flags[%0d]: got level=%0d empty=%b ae=%b want %0d %b %b",
                 i, level, empty, almost_empty, 15 - i, (i == 15), (15 - i <= 4));
      end
    end
    exp_r = 5'd21;
  endtask

  task automatic test_empty_rw();
    set_req(1'b1, 1'b1, 1'b0);
    checks++;
    if ({mem_we, mem_re} !== 2'b10) begin
      errors++;
      $display("FAIL empty_rw_strobe: got we=%b re=%b want 1 0", mem_we, mem_re);
    end
    tick();
    checks++;
    if ({level, underflow, rd_valid, empty} !== {5'd1, 3'b100}) begin
      errors++;
      $display("FAIL empty_rw_state: got level=%0d unf=%b rd_valid=%b empty=%b want 1 1 0 0",
               level, underflow, rd_valid, empty);
    end
    set_req(1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: got %b want 0", underflow);
    end
    lvl = 1; exp_w = 5'd22;
  endtask

  task automatic test_stream();
    int   writes = 0;
    logic up = 1'b1;
    logic w, r;
    while (writes < 40) begin
      if (up && lvl == 8) up = 1'b0;
      else if (!up && lvl == 2) up = 1'b1;
      w = up; r = ~up;
      set_req(w, r, 1'b0);
      checks++;
      if ({mem_we, mem_re, waddr, raddr} !== {w, r, exp_w[3:0], exp_r[3:0]}) begin
        errors++;
        $display("FAIL stream_strobe: got we=%b re=%b waddr=%0d raddr=%0d want %b %b %0d %0d",
                 mem_we, mem_re, waddr, raddr, w, r, exp_w[3:0], exp_r[3:0]);
      end
      tick();
      if (w) begin exp_w++; lvl++; writes++; end
      if (r) begin exp_r++; lvl--; end
      checks++;
      if ({level, empty, full, almost_empty} !== {5'(lvl), 2'b00, (lvl <= 4)}) begin
        errors++;
        $display("FAIL stream_flags: got level=%0d empty=%b full=%b ae=%b want %0d 0 0 %b",
                 level, empty, full, almost_empty, lvl, (lvl <= 4));
      end
    end
  endtask

  task automatic test_reset_mid();
    while (lvl < 17) begin
      set_req(1'b1, 1'b0, 1'b0);
      tick();
      if (lvl < 16) lvl++; else lvl = 17;
    end
    lvl = 16;
    while (lvl > 10) begin
      set_req(1'b0, 1'b1, 1'b0);
      tick();
      lvl--;
    end
    set_req(1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if ({level, rd_valid, overflow} !== {5'd9, 2'b11}) begin
      errors++;
      $display("FAIL pre_reset: got level=%0d rd_valid=%b ovf=%b want 9 1 1", level, rd_valid, overflow);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({level, empty, rd_valid, overflow, underflow, mem_re} !== {5'd0, 5'b10000}) begin
      errors++;
      $display("FAIL reset_mid: got level=%0d empty=%b rd_valid=%b ovf=%b unf=%b re=%b want 0 1 0 0 0 0",
               level, empty, rd_valid, overflow, underflow, mem_re);
    end
    @(negedge clk);
    rst = 1'b0; rd_req = 1'b0;
    tick();
    checks++;
    if ({level, empty, waddr, raddr} !== {5'd0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL post_reset: got level=%0d empty=%b waddr=%0d raddr=%0d want 0 1 0 0",
               level, empty, waddr, raddr);
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_full_rw();
    test_drain();
    test_empty_rw();
    test_stream();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
